mem_line_responder: RTL
=======================

# mem_line_responder

Memory-side responder for the cache-line main-memory interface: it accepts `type_cache2mem_s` line requests from the memory arbiter and returns `type_mem2cache_s` responses. Each 128-bit line is served from a word-wide, single-port synchronous SRAM over multiple beats, with configurable extra latency to model slower memory. It is a synthesizable drop-in at the memory end of the arbiter for non-DRAM builds and for bench use.

## Interface
- `LINE_WIDTH`, 128: cache line width in bits; must match `cache2mem_i.w_data` and `mem2cache_o.r_data`.
- `WORD_WIDTH`, 32: SRAM word width; `BEATS = LINE_WIDTH/WORD_WIDTH`, which must be a power of two.
- `MEM_DEPTH_WORDS`, 16384: number of SRAM words; must be a power of two.
- `EXTRA_LATENCY`, 0: added wait cycles before `ack`, range 0..200.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cache2mem_i`  in  `type_cache2mem_s`  request: `addr`, `w_data`, `w_en`, `req`.
- `mem2cache_o`  out  `type_mem2cache_s`  response: `r_data`, `ack`.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, ACK.
- **IDLE:**
  - When `req` is 1, latch `addr`, `w_en` and `w_data` into request registers, clear the beat counter and the wait counter, and go to ACCESS.
  - When `req` is 0, stay in IDLE.
- **ACCESS:**
  - Issue one SRAM access per cycle for beat `b` = 0..BEATS-1.
  - SRAM word index = `{addr[ADDR_W-1:log2(LINE_WIDTH/8)], b}` modulo `MEM_DEPTH_WORDS`.
  - Upper address bits beyond the depth are ignored, so accesses wrap.
  - Line byte-offset bits are ignored.
  - Write: store `w_data[b*WORD_WIDTH +: WORD_WIDTH]`.
  - Read: the SRAM returns data one cycle after the access. That word is stored into line-buffer slot `b` (beat 0 goes to `r_data[31:0]`; little-endian word order).
  - After beat BEATS-1 is issued, go to WAIT.
- **WAIT:**
  - Captures the last read word.
  - Then counts `EXTRA_LATENCY` further cycles and goes to ACK.
- **ACK:**
  - `ack` = 1 for exactly one cycle.
  - `r_data` = line buffer on reads, 0 on writes.
  - Then go to IDLE.
- **Req deasserted early:** the request is always completed and acknowledged, even if `req` drops before ACK. The arbiter's kill states (DKILL/IKILL) depend on this: they wait for `ack` while holding the request.
- **Back-to-back requests:** a `req` seen in the IDLE cycle immediately after ACK is accepted. No gap cycle is required.
- **Request changes mid-flight:** changes to `cache2mem_i` after acceptance are ignored until the next IDLE.
- **SRAM contents:** not reset.

## Timing
- **Reset values:** state IDLE; `ack` 0; `r_data` 0; `busy_o` 0; counters 0.
- **Latency:** request accepted in cycle 0, `ack` in cycle `BEATS + 2 + EXTRA_LATENCY` (6 with defaults), identical for reads and writes.
- **Timeout bound:** the worst case (including stalls) must stay below the arbiter's 0xEF kill timeout. With stalls enabled and defaults, the worst case is 6 + 3·BEATS = 18 cycles.
- **Outputs:** `ack` and `r_data` are registered (driven from ACK state flops) and are 0 outside the ACK cycle.
- **Reset mid-operation:** return to IDLE immediately and no `ack` is produced. Write beats issued before reset remain in the SRAM; later beats are not written.

## Configuration
- **`MEM_RESP_STALL_EN` defined:**
  - A 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - In ACCESS, when LFSR[1:0] == 2'b00 the current beat is not issued and the beat counter holds.
  - At most 3 consecutive stall cycles per beat; the 4th cycle forces issue.
  - Read data capture still follows the access that was actually issued.
- **`MEM_RESP_STALL_EN` undefined:** no LFSR and no stalls; latency is exactly as given under Timing.

## Structure
- **Shared defs:**
  - `type_mem_resp_states_e` goes into the shared cache defs header, next to `type_cache2mem_s` and `type_mem2cache_s`.
  - Also add the beat-count and offset-width constants derived from the line and word widths.
- **Sub-module `mem_resp_sram`:** single-port, word-wide, synchronous-read SRAM with ports `clk`, `en`, `we`, `addr`, `wdata`, `rdata`.
- **`mem_line_responder` itself:** the FSM, counters, request registers, line buffer and the optional LFSR.

## Test plan
- Write line 0x1000 with data 128'h0000000D_0000000C_0000000B_0000000A, then read 0x1000 -> `ack` 6 cycles after each accept; read returns the same 128 bits; SRAM words 0x400..0x403 = A,B,C,D.
- Read 0x100C (same line, non-zero offset) -> identical data to reading 0x1000.
- Address 0x10000 + 0x1000 with default depth -> wraps and aliases line 0x1000.
- Drop `req` in cycle 2 of a read -> `ack` still pulses exactly once in cycle 6; `busy_o` falls in cycle 7.
- Assert reset in cycle 3 of a write -> no `ack`; after reset `busy_o` = 0 and beats 0..1 are written while beats 2..3 are unchanged.
- With `MEM_RESP_STALL_EN` defined, run 1000 random reads and writes against a reference model -> data matches, every `ack` arrives within 18 cycles, and there is exactly one `ack` per accepted request.

Source files
------------

// File: rtl/mem_line_responder_pkg.sv
// Shared cache/memory interface definitions: request/response line structs,
// responder FSM states and the beat/offset constants derived from the widths.
`timescale 1ns/1ps
package mem_line_responder_pkg;

  localparam int unsigned CACHE_ADDR_W = 32;
  localparam int unsigned CACHE_LINE_W = 128;
  localparam int unsigned MEM_WORD_W   = 32;
  localparam int unsigned MEM_BEATS    = CACHE_LINE_W / MEM_WORD_W;
  localparam int unsigned MEM_BEAT_W   = $clog2(MEM_BEATS);
  localparam int unsigned LINE_OFF_W   = $clog2(CACHE_LINE_W / 8);

  typedef struct packed {
    logic [CACHE_ADDR_W-1:0] addr;
    logic [CACHE_LINE_W-1:0] w_data;
    logic                    w_en;
    logic                    req;
  } type_cache2mem_s;

  typedef struct packed {
    logic [CACHE_LINE_W-1:0] r_data;
    logic                    ack;
  } type_mem2cache_s;

  typedef enum logic [1:0] {
    MEM_RESP_IDLE   = 2'd0,
    MEM_RESP_ACCESS = 2'd1,
    MEM_RESP_WAIT   = 2'd2,
    MEM_RESP_ACK    = 2'd3
  } type_mem_resp_states_e;

endpackage

// File: rtl/mem_line_responder_sram.sv
// Single-port, word-wide SRAM with synchronous read. Contents are not reset.
`timescale 1ns/1ps
module mem_resp_sram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16384
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // One access per enabled cycle: write the word, or register the read word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side line responder: serves 128-bit cache-line requests from a
// word-wide SRAM over several beats, with optional extra wait latency.
// Optional random access stalls are enabled by defining MEM_RESP_STALL_EN.
`timescale 1ns/1ps
module mem_line_responder
  import mem_line_responder_pkg::*;
#(
  parameter int unsigned LINE_WIDTH      = CACHE_LINE_W,
  parameter int unsigned WORD_WIDTH      = MEM_WORD_W,
  parameter int unsigned MEM_DEPTH_WORDS = 16384,
  parameter int unsigned EXTRA_LATENCY   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  type_cache2mem_s cache2mem_i,
  output type_mem2cache_s mem2cache_o,
  output logic            busy_o
);

  localparam int unsigned BEATS   = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned BEAT_W  = $clog2(BEATS);
  localparam int unsigned OFF_W   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned DEPTH_W = $clog2(MEM_DEPTH_WORDS);
  localparam int unsigned IDX_W   = DEPTH_W - BEAT_W;
  localparam int unsigned WAIT_W  = 8;

  type_mem_resp_states_e r_state, w_state_next;

  logic [IDX_W-1:0]      r_line_idx;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_w_en;
  logic [BEAT_W-1:0]     r_beat;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic                  r_rd_pend;
  logic [BEAT_W-1:0]     r_rd_slot;
  logic [LINE_WIDTH-1:0] r_line;
  logic [LINE_WIDTH-1:0] r_rdata;
  logic                  r_ack;

  logic                  w_stall;
  logic                  w_issue;
  logic                  w_last_beat;
  logic                  w_wait_done;
  logic [DEPTH_W-1:0]    w_sram_addr;
  logic [WORD_WIDTH-1:0] w_wr_word;
  logic [WORD_WIDTH-1:0] w_sram_rdata;
  logic [LINE_WIDTH-1:0] w_line_next;
  logic                  w_unused;

  // Byte-offset bits and address bits above the SRAM depth never reach the array.
  assign w_unused = ^{cache2mem_i.addr[OFF_W-1:0],
                      cache2mem_i.addr[CACHE_ADDR_W-1:OFF_W+IDX_W]};

`ifdef MEM_RESP_STALL_EN
  logic [15:0] r_lfsr;
  logic [1:0]  r_stall_cnt;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_stall   = (r_state == MEM_RESP_ACCESS) && (r_lfsr[1:0] == 2'b00) &&
                     (r_stall_cnt != 2'd3);

  // Free-running LFSR and per-beat stall count (capped so a beat issues by its 4th cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= 16'hACE1;
      r_stall_cnt <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 2'd1;
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  assign w_issue     = (r_state == MEM_RESP_ACCESS) && !w_stall;
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_wait_done = (r_wait_cnt == WAIT_W'(EXTRA_LATENCY));
  assign w_sram_addr = {r_line_idx, r_beat};

  // Select the write word for the current beat and merge any returning read word.
  always_comb begin
    w_wr_word   = '0;
    w_line_next = r_line;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (r_beat == BEAT_W'(i)) begin
        w_wr_word = r_wdata[i*WORD_WIDTH +: WORD_WIDTH];
      end
      if (r_rd_pend && (r_rd_slot == BEAT_W'(i))) begin
        w_line_next[i*WORD_WIDTH +: WORD_WIDTH] = w_sram_rdata;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MEM_RESP_IDLE:   if (cache2mem_i.req) w_state_next = MEM_RESP_ACCESS;
      MEM_RESP_ACCESS: if (w_issue && w_last_beat) w_state_next = MEM_RESP_WAIT;
      MEM_RESP_WAIT:   if (w_wait_done) w_state_next = MEM_RESP_ACK;
      MEM_RESP_ACK:    w_state_next = MEM_RESP_IDLE;
      default:         w_state_next = MEM_RESP_IDLE;
    endcase
  end

  // State, request capture, beat/wait counters, line buffer and registered response.
  // The read word returns a cycle after its access, so capture tracks the slot
  // of the access actually issued rather than the current beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MEM_RESP_IDLE;
      r_line_idx <= '0;
      r_wdata    <= '0;
      r_w_en     <= 1'b0;
      r_beat     <= '0;
      r_wait_cnt <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_slot  <= '0;
      r_line     <= '0;
      r_rdata    <= '0;
      r_ack      <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rd_pend <= w_issue && !r_w_en;
      r_rd_slot <= r_beat;
      r_line    <= w_line_next;
      r_ack     <= (w_state_next == MEM_RESP_ACK);
      r_rdata   <= ((w_state_next == MEM_RESP_ACK) && !r_w_en) ? w_line_next : '0;
      case (r_state)
        MEM_RESP_IDLE: begin
          if (cache2mem_i.req) begin
            r_line_idx <= cache2mem_i.addr[OFF_W +: IDX_W];
            r_wdata    <= cache2mem_i.w_data;
            r_w_en     <= cache2mem_i.w_en;
            r_beat     <= '0;
            r_wait_cnt <= '0;
          end
        end
        MEM_RESP_ACCESS: begin
          if (w_issue) r_beat <= r_beat + 1'b1;
        end
        MEM_RESP_WAIT: begin
          if (!w_wait_done) r_wait_cnt <= r_wait_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  mem_resp_sram #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (MEM_DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .en    (w_issue),
    .we    (r_w_en),
    .addr  (w_sram_addr),
    .wdata (w_wr_word),
    .rdata (w_sram_rdata)
  );

  assign mem2cache_o = {r_rdata, r_ack};
  assign busy_o      = (r_state != MEM_RESP_IDLE);

endmodule
